// File: rtl/skid_pipe_reg.sv
// skid_pipe_reg: parametrised pipeline-stage register with a valid/ready
// handshake and a 2-entry skid buffer. in_ready and out_valid come straight
// from flops, so a downstream stall never forms a combinational path back
// upstream. flush drops every held payload and leaves a bubble.
// Optional build macro SKID_PIPE_REG_STATS_EN adds a saturating stall
// counter (stall_cnt) and its synchronous clear input (stall_clr).
module skid_pipe_reg #(
  parameter int               WIDTH   = 69,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SKID_PIPE_REG_STATS_EN
  ,
  input  logic             stall_clr,
  output logic [15:0]      stall_cnt
`endif
);

  // State encoding is {skid_v, main_v}; 2'b10 cannot be reached.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL1 = 2'b01,
    ST_BAD   = 2'b10,
    ST_FULL2 = 2'b11
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             in_ready_r;
  logic             in_ready_s;
  logic [WIDTH-1:0] main_data_r;
  logic [WIDTH-1:0] main_data_s;
  logic [WIDTH-1:0] skid_data_r;
  logic [WIDTH-1:0] skid_data_s;
  logic             main_v_s;
  logic             in_fire_s;
  logic             out_fire_s;

  assign main_v_s   = state_r[0];
  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = main_v_s & out_ready;

  assign in_ready  = in_ready_r;
  assign out_valid = state_r[0];
  assign out_data  = main_data_r;

  // Next-state and data-path selection; flush overrides the handshake moves.
  always_comb begin
    state_s     = state_r;
    main_data_s = main_data_r;
    skid_data_s = skid_data_r;
    case (state_r)
      ST_EMPTY: begin
        if (in_fire_s) begin
          main_data_s = in_data;
          state_s     = ST_FULL1;
        end else begin
          state_s     = ST_EMPTY;
        end
      end
      ST_FULL1: begin
        if (in_fire_s && out_fire_s) begin
          main_data_s = in_data;
          state_s     = ST_FULL1;
        end else if (in_fire_s) begin
          // Downstream stalled: the new payload parks in the skid entry.
          skid_data_s = in_data;
          state_s     = ST_FULL2;
        end else if (out_fire_s) begin
          state_s     = ST_EMPTY;
        end else begin
          state_s     = ST_FULL1;
        end
      end
      ST_FULL2: begin
        // in_ready is low here, so only the drain side can move.
        if (out_fire_s) begin
          main_data_s = skid_data_r;
          state_s     = ST_FULL1;
        end else begin
          state_s     = ST_FULL2;
        end
      end
      default: begin
        state_s = ST_EMPTY;
      end
    endcase
    if (flush) begin
      // Valids clear, data registers keep their contents.
      state_s     = ST_EMPTY;
      main_data_s = main_data_r;
      skid_data_s = skid_data_r;
    end else begin
      state_s     = state_s;
    end
    // Ready for the next cycle is simply "skid entry will be free".
    in_ready_s = ~state_s[1];
  end

  // State, ready and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      main_data_r <= RST_VAL;
      skid_data_r <= RST_VAL;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= in_ready_s;
      main_data_r <= main_data_s;
      skid_data_r <= skid_data_s;
    end
  end

`ifdef SKID_PIPE_REG_STATS_EN
  logic [15:0] stall_cnt_r;

  assign stall_cnt = stall_cnt_r;

  // Saturating count of cycles where a valid payload waits on downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 16'd0;
    end else if (stall_clr) begin
      stall_cnt_r <= 16'd0;
    end else if (out_valid && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_skid_pipe_reg.sv
// tb_skid_pipe_reg: scoreboard bench for skid_pipe_reg. A queue holds the
// payloads the stage should be holding, in order; accepted inputs are
// pushed, consumed outputs are popped and compared.
module tb_skid_pipe_reg;

  localparam int W = 69;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         stall_clr;
  logic [15:0]  stall_cnt;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic         chk_en   = 1'b0;
  logic         last_fire_in;
  logic [15:0]  exp_cnt  = 16'd0;
  logic [W-1:0] q[$];
  logic [W-1:0] out_log[$];

  skid_pipe_reg #(.WIDTH(W), .RST_VAL({W{1'b0}})) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SKID_PIPE_REG_STATS_EN
    ,
    .stall_clr (stall_clr),
    .stall_cnt (stall_cnt)
`endif
  );

`ifndef SKID_PIPE_REG_STATS_EN
  assign stall_cnt = 16'd0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: compare against the scoreboard, then advance the model.
  task automatic step();
    logic fire_in;
    logic fire_out;
    logic stall;
    if (chk_en) begin
      check("out_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, (q.size() > 0)});
      check("in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, (q.size() < 2)});
      if (q.size() > 0) check("out_data", out_data, q[0]);
`ifdef SKID_PIPE_REG_STATS_EN
      check("stall_cnt", {{(W-16){1'b0}}, stall_cnt}, {{(W-16){1'b0}}, exp_cnt});
`endif
    end
    if (out_valid === 1'b1 && out_ready && !rst) out_log.push_back(out_data);
    fire_in  = !rst && !flush && in_valid && (q.size() < 2);
    fire_out = out_ready && (q.size() > 0);
    stall    = (q.size() > 0) && !out_ready;
    @(posedge clk);
    if (rst) begin
      q.delete();
      exp_cnt = 16'd0;
    end else begin
      if (stall_clr) exp_cnt = 16'd0;
      else if (stall && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      else exp_cnt = exp_cnt;
      if (flush) begin
        q.delete();
      end else begin
        if (fire_out) void'(q.pop_front());
        if (fire_in) q.push_back(in_data);
      end
    end
    last_fire_in = fire_in;
    @(negedge clk);
  endtask

  initial begin
    logic [95:0] rnd;
    logic        done;
    rst = 1'b1; in_valid = 1'b1; in_data = 69'h1_2345; flush = 1'b0;
    out_ready = 1'b0; stall_clr = 1'b0;
    @(negedge clk);
    // Reset, held with a valid input present.
    step();
    check("rst_out_valid", {{(W-1){1'b0}}, out_valid}, {W{1'b0}});
    check("rst_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});
    check("rst_out_data", out_data, {W{1'b0}});
    step();
    rst = 1'b0; in_valid = 1'b0;
    step();
    check("post_rst_out_valid", {{(W-1){1'b0}}, out_valid}, {W{1'b0}});
    check("post_rst_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});
    check("post_rst_out_data", out_data, {W{1'b0}});
    chk_en = 1'b1;

    // Streaming with downstream always ready.
    out_log.delete();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = W'(i);
      check("stream_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});
      step();
    end
    in_valid = 1'b0;
    step(); step();
    check("stream_count", W'(out_log.size()), W'(8));
    for (int i = 0; i < 8 && i < out_log.size(); i++)
      check("stream_order", out_log[i], W'(i + 1));

    // Back-pressure: third payload must wait at the input.
    out_log.delete();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = W'(8'hA1); step();
    in_data = W'(8'hA2); step();
    in_data = W'(8'hA3);
    check("bp_in_ready_low", {{(W-1){1'b0}}, in_ready}, {W{1'b0}});
    step(); step();
    check("bp_still_low", {{(W-1){1'b0}}, in_ready}, {W{1'b0}});
    out_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      done = last_fire_in;
    end
    if (!done) check("bp_timeout", {W{1'b0}}, {{(W-1){1'b0}}, 1'b1});
    in_valid = 1'b0;
    repeat (4) step();
    check("bp_count", W'(out_log.size()), W'(3));
    if (out_log.size() == 3) begin
      check("bp_first", out_log[0], W'(8'hA1));
      check("bp_second", out_log[1], W'(8'hA2));
      check("bp_third", out_log[2], W'(8'hA3));
    end

    // Flush while both entries are occupied, with a payload offered.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = W'(8'hB1); step();
    in_data = W'(8'hB2); step();
    in_data = W'(8'hB3); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", {{(W-1){1'b0}}, out_valid}, {W{1'b0}});
    check("flush_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});
    out_log.delete();
    out_ready = 1'b1;
    repeat (3) step();
    check("flush_nothing_out", W'(out_log.size()), W'(0));

    // Accept and deliver in the same cycle from FULL1.
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(8'hC1); step();
    in_data = W'(8'hC2); out_ready = 1'b1; step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("simul_out_data", out_data, W'(8'hC2));
    check("simul_out_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, 1'b1});
    check("simul_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});
    step();

`ifdef SKID_PIPE_REG_STATS_EN
    // Stall counter: five stalled cycles, then clear together with flush.
    flush = 1'b1; stall_clr = 1'b1; step();
    flush = 1'b0; stall_clr = 1'b0;
    in_valid = 1'b1; in_data = W'(8'hD1); out_ready = 1'b0; step();
    in_valid = 1'b0;
    repeat (5) step();
    check("stall_five", {{(W-16){1'b0}}, stall_cnt}, W'(5));
    stall_clr = 1'b1; flush = 1'b1; step();
    stall_clr = 1'b0; flush = 1'b0;
    check("stall_cleared", {{(W-16){1'b0}}, stall_cnt}, W'(0));
`endif

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      rnd       = {$urandom, $urandom, $urandom};
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = rnd[W-1:0];
      out_ready = 1'($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      stall_clr = ($urandom_range(0, 30) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; stall_clr = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
